// File: rtl/hotp_truncate_bcd_pkg.sv
// Shared types and constants for the HOTP truncation + BCD conversion stage.
package hotp_truncate_bcd_pkg;

  localparam int unsigned DIGEST_W = 160;
  localparam int unsigned TRUNC_W  = 31;
  localparam int unsigned NIB_W    = 4;
  localparam int unsigned CNT_W    = 5;

  localparam logic [NIB_W-1:0] BCD_BLANK = 4'hF;
  // Last conversion step index (31 steps: 0..30)
  localparam logic [CNT_W-1:0] CNT_LAST  = 5'd30;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRUNC = 2'd1,
    ST_CONV  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/hotp_truncate_bcd_bcd_add3.sv
// Double-dabble correction cell: adds 3 to a BCD nibble that is 5 or more.
//   i_nib    : current BCD nibble
//   o_nib_c  : corrected nibble (combinational)
module bcd_add3
  import hotp_truncate_bcd_pkg::*;
(
  input  logic [NIB_W-1:0] i_nib,
  output logic [NIB_W-1:0] o_nib_c
);

  assign o_nib_c = (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;

endmodule

// File: rtl/hotp_truncate_bcd.sv
// RFC 4226 dynamic truncation of an HMAC-SHA1 digest followed by a serial
// double-dabble that leaves the value mod 10^DIGITS as packed BCD.
//   clk, rst_n      : clock, async active-low reset
//   digest_i        : 160-bit digest, byte 0 in [159:152]
//   digest_valid_i  : digest_i valid, held until accepted
//   digest_ready_o  : block can accept a digest (IDLE/DONE)
//   code_o          : packed BCD result, digit 0 in [3:0]
//   done_o          : code_o holds a completed result
//   digit_sel_i     : digit index for bcd_o
//   bcd_o           : selected digit, BCD_BLANK when out of range
module hotp_truncate_bcd
  import hotp_truncate_bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DIGEST_W-1:0]       digest_i,
  input  logic                      digest_valid_i,
  output logic                      digest_ready_o,
  output logic [NIB_W*DIGITS-1:0]   code_o,
  output logic                      done_o,
  input  logic [2:0]                digit_sel_i,
  output logic [NIB_W-1:0]          bcd_o
);

  localparam int unsigned CODE_W = NIB_W * DIGITS;

  state_t              r_state, n_state;
  logic [DIGEST_W-1:0] r_digest, n_digest;
  logic [TRUNC_W-1:0]  r_value, n_value;
  logic [CNT_W-1:0]    r_cnt, n_cnt;
  logic [CODE_W-1:0]   r_code, n_code;
  logic                r_done, n_done;
  logic                r_ready, n_ready;

  logic [TRUNC_W-1:0]  w_trunc;
  logic [CODE_W-1:0]   w_adj;
  // Byte 0 bit 7 is always masked and byte 19 only supplies the offset nibble
  logic                w_unused;

  assign w_unused = ^{r_digest[DIGEST_W-1], r_digest[7:4]};

  // Truncation mux: 31 bits starting just below bit 7 of byte[off]
  always_comb begin
    w_trunc = '0;
    for (int k = 0; k < 16; k++) begin
      if (r_digest[3:0] == 4'(k)) begin
        w_trunc = r_digest[(DIGEST_W - 2 - 8*k) -: TRUNC_W];
      end
    end
  end

  // Per-digit add-3 correction ahead of each shift
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .i_nib   (r_code[NIB_W*g +: NIB_W]),
      .o_nib_c (w_adj[NIB_W*g +: NIB_W])
    );
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_digest <= '0;
      r_value  <= '0;
      r_cnt    <= '0;
      r_code   <= '0;
      r_done   <= 1'b0;
      r_ready  <= 1'b1;
    end else begin
      r_state  <= n_state;
      r_digest <= n_digest;
      r_value  <= n_value;
      r_cnt    <= n_cnt;
      r_code   <= n_code;
      r_done   <= n_done;
      r_ready  <= n_ready;
    end
  end

  // Next-state and next-datapath logic
  always_comb begin
    n_state  = r_state;
    n_digest = r_digest;
    n_value  = r_value;
    n_cnt    = r_cnt;
    n_code   = r_code;
    n_done   = r_done;
    n_ready  = r_ready;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (digest_valid_i) begin
          n_digest = digest_i;
          n_code   = '0;
          n_done   = 1'b0;
          n_ready  = 1'b0;
          n_state  = ST_TRUNC;
        end
      end
      ST_TRUNC: begin
        n_value = w_trunc;
        n_cnt   = '0;
        n_state = ST_CONV;
      end
      ST_CONV: begin
        // Carry out of the top digit falls off, giving mod 10^DIGITS
        {n_code, n_value} = {w_adj[CODE_W-2:0], r_value, 1'b0};
        n_cnt = r_cnt + 5'd1;
        if (r_cnt == CNT_LAST) begin
          n_state = ST_DONE;
          n_done  = 1'b1;
          n_ready = 1'b1;
        end
      end
      default: begin
        n_state = ST_IDLE;
        n_ready = 1'b1;
      end
    endcase
  end

  // Digit select for the display mux
  always_comb begin
    bcd_o = BCD_BLANK;
    for (int k = 0; k < DIGITS; k++) begin
      if (digit_sel_i == 3'(k)) begin
        bcd_o = r_code[NIB_W*k +: NIB_W];
      end
    end
  end

  assign digest_ready_o = r_ready;
  assign code_o         = r_code;
  assign done_o         = r_done;

endmodule

// File: doc/hotp_truncate_bcd.md
Name: hotp_truncate_bcd

Overview:
Downstream stage of the HMAC-SHA1 core in the TOTP/HOTP design. Takes a 160-bit HMAC digest and applies RFC 4226 dynamic truncation to get a 31-bit value. A serial double-dabble reduces that value mod 10^DIGITS into packed BCD digits. The result drives the 7-segment/BCD output mux, one digit at a time via a select input.

Parameters:
DIGITS, 6, number of decimal code digits kept (legal 6..8); result = truncated value mod 10^DIGITS

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
digest_i  input  160  HMAC-SHA1 output; byte 0 = digest_i[159:152], byte 19 = digest_i[7:0]
digest_valid_i  input  1  digest_i valid; held until accepted
digest_ready_o  output  1  block can accept a digest
code_o  output  4*DIGITS  packed BCD result; digit 0 (least significant) in [3:0]
done_o  output  1  code_o holds a completed result
digit_sel_i  input  3  digit index for bcd_o
bcd_o  output  4  selected digit of code_o; 4'hF when digit_sel_i >= DIGITS

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state IDLE, code_o = 0, done_o = 0, digest_ready_o = 1, internal registers 0.
- FSM states: IDLE, TRUNC, CONV, DONE.
- digest_ready_o = 1 in IDLE and DONE, 0 in TRUNC and CONV.
- Accept: on edge A with digest_valid_i & digest_ready_o:
  - Register digest_i.
  - Clear code_o to 0.
  - done_o = 0.
  - Next state TRUNC.
- TRUNC (edge A+1):
  - off = digest[3:0], the low nibble of byte 19.
  - Latch the 31-bit value {byte[off][6:0], byte[off+1], byte[off+2], byte[off+3]}.
  - Set the bit counter to 0. Next state CONV.
- CONV (edges A+2 .. A+32, 31 steps, MSB first):
  - First, every BCD nibble >= 5 gets +3.
  - Then {bcd, value} shifts left 1.
  - The nibble carried out of the top digit is discarded. This yields mod 10^DIGITS exactly.
  - After step 31: next state DONE, done_o = 1.
  - Latency: done_o is high after edge A+32, i.e. 32 cycles after the accepting edge.
- DONE: code_o and done_o hold until the next accept.
  - A new accept in DONE behaves as in IDLE: done_o falls on the accepting edge.
- digest_valid_i while busy (TRUNC/CONV): ignored, no effect on the in-flight conversion. The upstream stage holds it.
- code_o during CONV shows the partial register. Consumers qualify it with done_o.
- bcd_o is combinational from code_o and digit_sel_i.
- Reset asserted mid-operation: immediate return to reset values, and any partial result is lost.
- Arithmetic:
  - Truncation always masks bit 7 of byte[off], so the value is < 2^31.
  - off = 15 uses bytes 15..18, so no wrap-around is needed.
  - Counter width is 5 bits and terminates at 30.

Decomposition:
- Shared package:
  - FSM state enum (IDLE/TRUNC/CONV/DONE).
  - DIGEST_W = 160, TRUNC_W = 31, BCD_BLANK = 4'hF.
- Sub-module: bcd_add3, a combinational per-nibble "if >= 5 add 3" cell, instantiated DIGITS times.
- Truncation mux and FSM stay in the top block.

Test Plan:
- RFC 4226 count 0, digest cc93cf18508d94934c64b65d8ba7667fb7cde4b0:
  - Truncated 0x4c93cf18.
  - done_o high exactly 32 cycles after accept.
  - code_o = 0x755224.
  - digit_sel 0..5 gives bcd_o 4,2,2,5,5,7.
  - digit_sel 6 gives 4'hF.
- RFC 4226 count 1, digest 75a48a19d4cbe100644e8ac1397eea747a2d33ab: code_o = 0x287082.
- RFC 4226 §5.4 digest 1f8698690e02ca16618550ef7f19da8e945b555a:
  - off = 0xA, truncated 0x50ef7f19.
  - code_o = 0x872921.
  - With DIGITS=8: code_o = 0x57872921.
- Boundary: all-0xFF digest gives off = 15 and value 0x7fffffff.
  - code_o = 0x483647.
  - All-zero digest gives code_o = 0x000000 with done_o = 1.
- Handshake:
  - Hold digest_valid_i high through CONV with a different digest: ready stays 0 and the first result is unaffected.
  - Accept in DONE: done_o drops on the accepting edge and the second result appears 32 cycles later.
- Reset: assert rst_n = 0 at CONV step 10. Outputs reach reset values at once (ready 1, done 0, code_o 0).
  - A following accept produces a correct result.
